// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types, field widths and helpers for the direct-mapped
//               read-only instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int TAG_W    = 3;     // PC[9:7]
    localparam int INDEX_W  = 3;     // PC[6:4]
    localparam int OFFSET_W = 2;     // PC[3:2]
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;   // four instructions per line

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // Word 0 lives in the most significant 32 bits of a line.
    function automatic logic [WORD_W-1:0] line_word(
        input logic [LINE_W-1:0]   line,
        input logic [OFFSET_W-1:0] k
    );
        line_word = line[(LINE_W - 1 - WORD_W * int'(k)) -: WORD_W];
    endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/instruction_cache_array.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache_array
// Description : Valid/tag/data storage for the instruction cache. One
//               asynchronous read port, one synchronous line-fill port,
//               valid bits cleared asynchronously by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache_array #(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 3,
    parameter int LINE_W    = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_line
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [LINE_W-1:0]    lines [NUM_LINES];

    // Valid bits: cleared on reset, set when a line is filled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage: plain write port, contents qualified by valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_line  = lines[rd_index];

endmodule : instruction_cache_array
`default_nettype wire

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// Module      : instruction_cache
// Description : Direct-mapped read-only instruction cache. Zero-cycle hits;
//               on a miss the CPU is stalled while one 16-byte block is
//               fetched from instruction memory and written into the line.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_cache
    import icache_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                      CLK,
    input  logic                                      RESET,
    input  logic [31:0]                               PC,
    output logic [31:0]                               INSTRUCTION,
    output logic                                      BUSYWAIT,
    output logic                                      MEM_READ,
    output logic [ADDR_W-$clog2(WORDS_PER_LINE)-3:0]  MEM_ADDRESS,
    input  logic [LINE_W-1:0]                         MEM_READDATA,
    input  logic                                      MEM_BUSYWAIT
);

    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int BLK_W    = ADDR_W - OFF_W - 2;
    localparam int TAG_BITS = BLK_W - IDX_W;

    state_t             state;
    logic [BLK_W-1:0]   miss_block;
    logic               mem_read;

    logic [TAG_BITS-1:0] pc_tag;
    logic [IDX_W-1:0]    pc_index;
    logic [OFF_W-1:0]    pc_offset;
    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                hit;
    logic                fill_en;
    logic                unused_pc_bits;

    assign pc_tag         = PC[ADDR_W-1 -: TAG_BITS];
    assign pc_index       = PC[OFF_W+2 +: IDX_W];
    assign pc_offset      = PC[2 +: OFF_W];
    assign unused_pc_bits = &{1'b0, PC[31:ADDR_W], PC[1:0]};

    instruction_cache_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (IDX_W),
        .TAG_W     (TAG_BITS),
        .LINE_W    (LINE_W)
    ) u_array (
        .clk      (CLK),
        .reset_n  (RESET),
        .rd_index (pc_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (fill_en),
        .wr_index (miss_block[IDX_W-1:0]),
        .wr_tag   (miss_block[BLK_W-1:IDX_W]),
        .wr_line  (MEM_READDATA)
    );

    assign hit     = rd_valid && (rd_tag == pc_tag);
    // Line is written on the same edge that leaves FETCH; a reset forces
    // state back to IDLE asynchronously so an aborted fill never writes.
    assign fill_en = (state == FETCH) && !MEM_BUSYWAIT;

    // Miss handling FSM: latch the block address, fetch, then one update cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            miss_block <= '0;
            mem_read   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit) begin
                        miss_block <= PC[ADDR_W-1:OFF_W+2];
                        mem_read   <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        mem_read <= 1'b0;
                        state    <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_read <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // The stall and instruction outputs are forced quiet while in reset even
    // though every line reads as a miss then.
    assign BUSYWAIT    = RESET && ((state != IDLE) || !hit);
    assign INSTRUCTION = (RESET && (state == IDLE) && hit) ?
                         line_word(rd_line, pc_offset) : 32'h0;
    assign MEM_READ    = mem_read;
    assign MEM_ADDRESS = miss_block;

endmodule : instruction_cache
`default_nettype wire
